// File: rtl/tt_pwr_seq_pkg.sv
// Shared state encoding and constant helpers for the tile power sequencer.
// No latency or backpressure: declarations only.
package tt_pwr_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_UP     = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ON     = 3'd3,
        ST_DOWN   = 3'd4
    } pwr_state_t;

    // Smallest r with 2**r >= value; evaluated at elaboration only.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tt_pwr_seq_cnt.sv
// Loadable saturating down-counter with zero and one flags.
// Latency: load/decrement visible one cycle later. No backpressure.
module tt_pwr_seq_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             one
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign one  = (cnt == CNT_W'(1));

endmodule

// File: rtl/tt_pwr_seq.sv
// Staged power-switch sequencer: ramps switch groups up/down with fixed spacing.
// Latency: all outputs registered; stage changes every STEP_CYCLES. No backpressure.
module tt_pwr_seq
    import tt_pwr_seq_pkg::*;
#(
    parameter int N_STAGES      = 4,
    parameter int STEP_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    output logic [N_STAGES-1:0] stage_en,
    output logic                iso,
    output logic                pwr_good,
    output logic                busy
);

    localparam int CNT_MAX = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] STEP_LD   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    // A single settle cycle is already covered by the edge that leaves UP.
    localparam bit SKIP_SETTLE = (SETTLE_CYCLES == 1);

    pwr_state_t          state, state_nxt;
    logic [N_STAGES-1:0] stage_nxt;
    logic                cnt_load, cnt_dec, cnt_zero, cnt_one;
    logic [CNT_W-1:0]    cnt_ld_val;
    logic                iso_nxt, pwr_good_nxt, busy_nxt;

    tt_pwr_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_OFF;
            stage_en <= '0;
            iso      <= 1'b1;
            pwr_good <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            stage_en <= stage_nxt;
            iso      <= iso_nxt;
            pwr_good <= pwr_good_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        stage_nxt  = stage_en;
        cnt_load   = 1'b0;
        cnt_ld_val = STEP_LD;
        cnt_dec    = 1'b0;
        case (state)
            ST_OFF: begin
                if (req) begin
                    state_nxt = ST_UP;
                    stage_nxt = N_STAGES'(1);
                    cnt_load  = 1'b1;
                end
            end
            ST_UP: begin
                if (!req) begin
                    state_nxt = ST_DOWN;
                    cnt_load  = 1'b1;
                end else if (cnt_zero) begin
                    if (stage_en[N_STAGES-1]) begin
                        if (SKIP_SETTLE) begin
                            state_nxt = ST_ON;
                        end else begin
                            state_nxt  = ST_SETTLE;
                            cnt_load   = 1'b1;
                            cnt_ld_val = SETTLE_LD;
                        end
                    end else begin
                        stage_nxt = (stage_en << 1) | N_STAGES'(1);
                        cnt_load  = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                // Power good asserts on the edge that takes the counter to zero.
                if (!req) begin
                    state_nxt = ST_DOWN;
                    cnt_load  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_one || cnt_zero) begin
                        state_nxt = ST_ON;
                    end
                end
            end
            ST_ON: begin
                if (!req) begin
                    state_nxt = ST_DOWN;
                    cnt_load  = 1'b1;
                end
            end
            ST_DOWN: begin
                // req is ignored here so the rail always fully discharges.
                if (cnt_zero) begin
                    stage_nxt = stage_en >> 1;
                    cnt_load  = 1'b1;
                    if ((stage_en >> 1) == '0) begin
                        state_nxt = ST_OFF;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_OFF;
                stage_nxt = '0;
            end
        endcase

        iso_nxt      = (state_nxt != ST_ON);
        pwr_good_nxt = (state_nxt == ST_ON);
        busy_nxt     = (state_nxt == ST_UP) || (state_nxt == ST_SETTLE) || (state_nxt == ST_DOWN);
    end

endmodule

// File: tb/tb_tt_pwr_seq.sv
// Bench for tt_pwr_seq: default build plus the 1/1/1 corner, against a phase/elapsed-time model.
module tb_tt_pwr_seq;

    localparam int PH_OFF = 0;
    localparam int PH_UP  = 1;
    localparam int PH_ON  = 2;
    localparam int PH_DN  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       req, req_c;
    logic [3:0] se;
    logic       iso, pg, busy;
    logic [0:0] se_c;
    logic       iso_c, pg_c, busy_c;

    tt_pwr_seq dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .stage_en (se),
        .iso      (iso),
        .pwr_good (pg),
        .busy     (busy)
    );

    tt_pwr_seq #(
        .N_STAGES      (1),
        .STEP_CYCLES   (1),
        .SETTLE_CYCLES (1)
    ) dut_c (
        .clk      (clk),
        .rst      (rst),
        .req      (req_c),
        .stage_en (se_c),
        .iso      (iso_c),
        .pwr_good (pg_c),
        .busy     (busy_c)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int p_n[2] = '{4, 1};
    int p_s[2] = '{16, 1};
    int p_t[2] = '{32, 1};
    int m_ph[2], m_t[2], m_n[2], m_n0[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = PH_OFF;
            m_t[i]  = 0;
            m_n[i]  = 0;
            m_n0[i] = 0;
        end
    endtask

    // Stages on = 1 + elapsed/STEP while ramping; power good at N*STEP + SETTLE - 1.
    task automatic model_edge(input int i, input logic r);
        case (m_ph[i])
            PH_OFF: if (r) begin
                m_ph[i] = PH_UP;
                m_t[i]  = 0;
                m_n[i]  = 1;
            end
            PH_UP: begin
                m_t[i]++;
                if (!r) begin
                    m_ph[i] = PH_DN;
                    m_t[i]  = 0;
                    m_n0[i] = m_n[i];
                end else begin
                    m_n[i] = (1 + m_t[i] / p_s[i] > p_n[i]) ? p_n[i] : 1 + m_t[i] / p_s[i];
                    if (m_t[i] == p_n[i] * p_s[i] + p_t[i] - 1) m_ph[i] = PH_ON;
                end
            end
            PH_ON: if (!r) begin
                m_ph[i] = PH_DN;
                m_t[i]  = 0;
                m_n0[i] = m_n[i];
            end
            default: begin
                m_t[i]++;
                m_n[i] = m_n0[i] - m_t[i] / p_s[i];
                if (m_n[i] <= 0) begin
                    m_n[i]  = 0;
                    m_ph[i] = PH_OFF;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        chk("se_a",     32'(se), 32'((1 << m_n[0]) - 1));
        chk("iso_a",    32'(iso), 32'(m_ph[0] != PH_ON));
        chk("pg_a",     32'(pg), 32'(m_ph[0] == PH_ON));
        chk("busy_a",   32'(busy), 32'(m_ph[0] == PH_UP || m_ph[0] == PH_DN));
        chk("thermo_a", 32'((se & (se + 4'd1)) == 4'd0), 32'd1);
        chk("pgiso_a",  32'(pg), 32'(!iso));
        chk("se_c",     32'(se_c), 32'((1 << m_n[1]) - 1));
        chk("iso_c",    32'(iso_c), 32'(m_ph[1] != PH_ON));
        chk("pg_c",     32'(pg_c), 32'(m_ph[1] == PH_ON));
        chk("busy_c",   32'(busy_c), 32'(m_ph[1] == PH_UP || m_ph[1] == PH_DN));
        chk("pgiso_c",  32'(pg_c), 32'(!iso_c));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            model_edge(0, req);
            model_edge(1, req_c);
        end
        #1;
        compare_all();
    endtask

    initial begin
        int k, j, pg_at, pgc_at, off_at;
        rst   = 1'b0;
        req   = 1'b1;
        req_c = 1'b1;
        model_reset();
        #2 rst = 1'b1;
        #1 compare_all();
        repeat (3) step();
        rst = 1'b0;

        // Full ramp with defaults.
        step();
        k = cyc;
        chk("first_stage", 32'(se), 32'd1);
        pg_at  = -1;
        pgc_at = -1;
        for (int w = 0; w < 200 && pg_at < 0; w++) begin
            step();
            if (pg_c && pgc_at < 0) pgc_at = cyc;
            if (pg && pg_at < 0) pg_at = cyc;
        end
        chk("pg_latency", 32'(pg_at - k), 32'd95);
        chk("pgc_latency", 32'(pgc_at - k), 32'd1);
        repeat (5) step();

        // Full power-down.
        req   = 1'b0;
        req_c = 1'b0;
        step();
        j = cyc;
        chk("down_iso", 32'(iso), 32'd1);
        off_at = -1;
        for (int w = 0; w < 100 && off_at < 0; w++) begin
            step();
            if (!busy) off_at = cyc;
        end
        chk("off_latency", 32'(off_at - j), 32'd64);
        repeat (3) step();

        // Abort mid-ramp, then reassert during the discharge.
        req = 1'b1;
        for (int w = 0; w < 100 && se != 4'd3; w++) step();
        chk("abort_at", 32'(se), 32'd3);
        req = 1'b0;
        repeat (6) step();
        req = 1'b1;
        repeat (40) step();
        for (int w = 0; w < 200 && !pg; w++) step();
        chk("reup_pg", 32'(pg), 32'd1);

        // Async reset between edges while ON.
        req_c = 1'b1;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        rst = 1'b0;
        step();
        chk("restart_stage", 32'(se), 32'd1);

        // Random req activity on both builds.
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 19) == 0) req = ~req;
            if ($urandom_range(0, 3) == 0) req_c = ~req_c;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
